// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - opcodes and FSM state type shared by the serial ALU files
package serial_alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b0100;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } alu_state_t;

endpackage

// File: rtl/serial_alu_if.sv
// rtl/serial_alu_if.sv - start/done operation handshake and result bundle of the serial ALU
interface serial_alu_if #(parameter int WIDTH = 8);

   logic             start;
   logic [WIDTH-1:0] a_input;
   logic [WIDTH-1:0] b_input;
   logic             carry_in;
   logic [3:0]       alu_sel_line;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] alu_result;
   logic             carryout;
   logic             zero;
   logic             overflow;

   modport master (
      output start, a_input, b_input, carry_in, alu_sel_line,
      input  busy, done, alu_result, carryout, zero, overflow
   );

   modport slave (
      input  start, a_input, b_input, carry_in, alu_sel_line,
      output busy, done, alu_result, carryout, zero, overflow
   );

endinterface

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational one-bit ALU slice; chain is carry for ADD, borrow for SUB/SLT
module alu_bit_slice
   import serial_alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       chain_in,
   input  logic [3:0] sel,
   output logic       res,
   output logic       chain_out
);

   always_comb begin
      res       = 1'b0;
      chain_out = 1'b0;
      case (sel)
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         ALU_ADD: begin
            res       = a ^ b ^ chain_in;
            chain_out = (a & b) | (chain_in & (a ^ b));
         end
         ALU_SUB, ALU_SLT: begin
            res       = a ^ b ^ chain_in;
            chain_out = (~a & (b ^ chain_in)) | (b & chain_in);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial WIDTH-bit ALU, LSB first, one bit per clock
// SERIAL_ALU_OVERFLOW_EN builds signed overflow detection; otherwise overflow is tied to 0.
module serial_alu
   import serial_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   serial_alu_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   alu_state_t       state, state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_reg, b_reg, shreg, result_reg, final_res, shifted;
   logic [3:0]       sel_reg;
   logic             chain, carry_reg, zero_reg;
   logic             accept, last, s_res, s_chain, arith;

   alu_bit_slice u_slice (
      .a         (a_reg[cnt]),
      .b         (b_reg[cnt]),
      .chain_in  (chain),
      .sel       (sel_reg),
      .res       (s_res),
      .chain_out (s_chain)
   );

   assign accept  = bus.start && (state != RUN);
   assign last    = (state == RUN) && (cnt == CW'(WIDTH - 1));
   assign shifted = {s_res, shreg[WIDTH-1:1]};
   assign arith   = (sel_reg == ALU_ADD) || (sel_reg == ALU_SUB);
   // SLT only reports the final borrow of the subtract chain
   assign final_res = (sel_reg == ALU_SLT) ? {{(WIDTH-1){1'b0}}, s_chain} : shifted;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    state_next = bus.start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg      <= '0;
         b_reg      <= '0;
         sel_reg    <= '0;
         chain      <= 1'b0;
         cnt        <= '0;
         shreg      <= '0;
         result_reg <= '0;
         carry_reg  <= 1'b0;
         zero_reg   <= 1'b1;
      end else if (accept) begin
         a_reg   <= bus.a_input;
         b_reg   <= bus.b_input;
         sel_reg <= bus.alu_sel_line;
         chain   <= ((bus.alu_sel_line == ALU_ADD) || (bus.alu_sel_line == ALU_SUB)) ? bus.carry_in : 1'b0;
         cnt     <= '0;
         shreg   <= '0;
      end else if (state == RUN) begin
         cnt   <= cnt + CW'(1);
         shreg <= shifted;
         chain <= s_chain;
         // Flags land with the last bit so they appear together with done
         if (last) begin
            result_reg <= final_res;
            carry_reg  <= arith ? s_chain : 1'b0;
            zero_reg   <= (final_res == '0);
         end
      end
   end

`ifdef SERIAL_ALU_OVERFLOW_EN
   logic ov_reg, ov_next;

   always_comb begin
      ov_next = 1'b0;
      if (sel_reg == ALU_ADD)
         ov_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (s_res != a_reg[WIDTH-1]);
      else if (sel_reg == ALU_SUB)
         ov_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (s_res != a_reg[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (reset)     ov_reg <= 1'b0;
      else if (last) ov_reg <= ov_next;
   end

   assign bus.overflow = ov_reg;
`else
   assign bus.overflow = 1'b0;
`endif

   assign bus.busy       = (state == RUN);
   assign bus.done       = (state == DONE);
   assign bus.alu_result = result_reg;
   assign bus.carryout   = carry_reg;
   assign bus.zero       = zero_reg;

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - table-driven scoreboard bench for serial_alu at WIDTH=8
module tb_serial_alu;

   localparam int WIDTH = 8;
`ifdef SERIAL_ALU_OVERFLOW_EN
   localparam bit OV_EN = 1'b1;
`else
   localparam bit OV_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0] sel;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] res;
      logic       co;
      logic       ov;
      logic       b2b;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      logic       co;
      logic       ov;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   vec_t tbl[12];

   serial_alu_if #(.WIDTH(WIDTH)) bus ();

   serial_alu #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         check("done_busy_exclusive", 64'(bus.busy), 64'd0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done actual=1 expected=0");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 64'(bus.alu_result), 64'(e.res));
            check("carryout", 64'(bus.carryout), 64'(e.co));
            check("zero", 64'(bus.zero), 64'(e.res == 8'h00));
            check("overflow", 64'(bus.overflow), 64'(e.ov & OV_EN));
         end
      end
   end

   task automatic launch(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] res, input logic co,
                         input logic ov, input bit push);
      exp_t e;
      bus.start        = 1'b1;
      bus.alu_sel_line = sel;
      bus.a_input      = a;
      bus.b_input      = b;
      bus.carry_in     = cin;
      if (push) begin
         e.res = res;
         e.co  = co;
         e.ov  = ov;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.start        = 1'b0;
      bus.a_input      = 8'($urandom);
      bus.b_input      = 8'($urandom);
      bus.carry_in     = 1'($urandom);
      bus.alu_sel_line = 4'($urandom);
   endtask

   task automatic wait_done(input int c0, input int exp_busy);
      int c  = c0;
      int nb = 0;
      bit ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) nb++;
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         c++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=none expected=done");
      end else begin
         check("latency", 64'(c), 64'(WIDTH + 1));
         check("busy_cycles", 64'(nb), 64'(exp_busy));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{4'b0010, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{4'b0011, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{4'b0011, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{4'b0100, 8'h03, 8'h80, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{4'b0100, 8'h80, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{4'b0000, 8'hCC, 8'hAA, 1'b0, 8'h88, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{4'b0001, 8'hCC, 8'hAA, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{4'b0111, 8'hCC, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{4'b0010, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{4'b0010, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{4'b0011, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{4'b0100, 8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

      reset            = 1'b1;
      bus.start        = 1'b0;
      bus.a_input      = '0;
      bus.b_input      = '0;
      bus.carry_in     = 1'b0;
      bus.alu_sel_line = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_result", 64'(bus.alu_result), 64'd0);
      check("rst_carryout", 64'(bus.carryout), 64'd0);
      check("rst_zero", 64'(bus.zero), 64'd1);
      check("rst_overflow", 64'(bus.overflow), 64'd0);

      for (int i = 0; i < 12; i++) begin
         if (!tbl[i].b2b) idle(2);
         launch(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].res, tbl[i].co, tbl[i].ov, 1'b1);
         wait_done(1, WIDTH);
      end

      // Start pulse in the middle of RUN must be dropped
      idle(2);
      launch(4'b0010, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      bus.start        = 1'b1;
      bus.alu_sel_line = 4'b0010;
      bus.a_input      = 8'h55;
      bus.b_input      = 8'h33;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(4, WIDTH - 3);

      // Reset in cycle 4 of RUN aborts without a done
      idle(2);
      launch(4'b0010, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_result", 64'(bus.alu_result), 64'd0);
      check("abort_zero", 64'(bus.zero), 64'd1);
      idle(15);
      check("abort_no_done", 64'(bus.busy | bus.done), 64'd0);

      launch(4'b0010, 8'h21, 8'h12, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
      wait_done(1, WIDTH);
      idle(2);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
